// File: rtl/ctrl_decode_stage.sv
// Registered control decode stage between instruction decode and ID/EX: opcode decode, ARM condition check,
// valid/ready flow control and branch-shadow squashing. Define COND_EXEC_EN to enable conditional execution.
module ctrl_decode_stage #(
    parameter int MODE_LEN       = 2,
    parameter int OPCODE_LEN     = 4,
    parameter int EXE_CMD_LEN    = 4,
    parameter int BRANCH_PENALTY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MODE_LEN-1:0]    mode,
    input  logic [OPCODE_LEN-1:0]  opcode,
    input  logic                   s,
    input  logic [3:0]             cond,
    input  logic [3:0]             status,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXE_CMD_LEN-1:0] exe_cmd,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   wb_enable,
    output logic                   branch_taken,
    output logic                   status_write_enable,
    output logic                   undef
);

    localparam int CNT_W = (BRANCH_PENALTY < 1) ? 1 : $clog2(BRANCH_PENALTY + 1);
    localparam logic [CNT_W-1:0] PENALTY = CNT_W'(BRANCH_PENALTY);

    localparam logic [MODE_LEN-1:0] MODE_ARITH  = MODE_LEN'(0);
    localparam logic [MODE_LEN-1:0] MODE_MEM    = MODE_LEN'(1);
    localparam logic [MODE_LEN-1:0] MODE_BRANCH = MODE_LEN'(2);

    localparam logic [OPCODE_LEN-1:0] OP_MOV = OPCODE_LEN'(4'b1101);
    localparam logic [OPCODE_LEN-1:0] OP_MVN = OPCODE_LEN'(4'b1111);
    localparam logic [OPCODE_LEN-1:0] OP_ADD = OPCODE_LEN'(4'b0100);
    localparam logic [OPCODE_LEN-1:0] OP_ADC = OPCODE_LEN'(4'b0101);
    localparam logic [OPCODE_LEN-1:0] OP_SUB = OPCODE_LEN'(4'b0010);
    localparam logic [OPCODE_LEN-1:0] OP_SBC = OPCODE_LEN'(4'b0110);
    localparam logic [OPCODE_LEN-1:0] OP_AND = OPCODE_LEN'(4'b0000);
    localparam logic [OPCODE_LEN-1:0] OP_ORR = OPCODE_LEN'(4'b1100);
    localparam logic [OPCODE_LEN-1:0] OP_EOR = OPCODE_LEN'(4'b0001);
    localparam logic [OPCODE_LEN-1:0] OP_CMP = OPCODE_LEN'(4'b1010);
    localparam logic [OPCODE_LEN-1:0] OP_TST = OPCODE_LEN'(4'b1000);

    localparam logic [EXE_CMD_LEN-1:0] EXE_MOV = EXE_CMD_LEN'(4'b0001);
    localparam logic [EXE_CMD_LEN-1:0] EXE_MVN = EXE_CMD_LEN'(4'b1001);
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = EXE_CMD_LEN'(4'b0010);
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADC = EXE_CMD_LEN'(4'b0011);
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = EXE_CMD_LEN'(4'b0100);
    localparam logic [EXE_CMD_LEN-1:0] EXE_SBC = EXE_CMD_LEN'(4'b0101);
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND = EXE_CMD_LEN'(4'b0110);
    localparam logic [EXE_CMD_LEN-1:0] EXE_ORR = EXE_CMD_LEN'(4'b0111);
    localparam logic [EXE_CMD_LEN-1:0] EXE_EOR = EXE_CMD_LEN'(4'b1000);

    typedef struct packed {
        logic [EXE_CMD_LEN-1:0] exe_cmd;
        logic                   mem_read;
        logic                   mem_write;
        logic                   wb_enable;
        logic                   branch_taken;
        logic                   status_write_enable;
        logic                   undef;
    } ctrl_t;

    ctrl_t            dec;
    ctrl_t            ctrl_q;
    logic             cond_pass;
    logic             accept;
    logic [CNT_W-1:0] shadow_cnt;

    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    always_comb begin
        dec = '0;
        case (mode)
            MODE_ARITH: begin
                dec.wb_enable           = 1'b1;
                dec.status_write_enable = s;
                case (opcode)
                    OP_MOV:  dec.exe_cmd = EXE_MOV;
                    OP_MVN:  dec.exe_cmd = EXE_MVN;
                    OP_ADD:  dec.exe_cmd = EXE_ADD;
                    OP_ADC:  dec.exe_cmd = EXE_ADC;
                    OP_SUB:  dec.exe_cmd = EXE_SUB;
                    OP_SBC:  dec.exe_cmd = EXE_SBC;
                    OP_AND:  dec.exe_cmd = EXE_AND;
                    OP_ORR:  dec.exe_cmd = EXE_ORR;
                    OP_EOR:  dec.exe_cmd = EXE_EOR;
                    OP_CMP, OP_TST: begin
                        dec.exe_cmd             = (opcode == OP_CMP) ? EXE_SUB : EXE_AND;
                        dec.wb_enable           = 1'b0;
                        dec.status_write_enable = 1'b1;
                    end
                    default: begin
                        dec.undef               = 1'b1;
                        dec.wb_enable           = 1'b0;
                        dec.status_write_enable = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                dec.exe_cmd   = EXE_ADD;
                dec.mem_read  = s;
                dec.mem_write = !s;
                dec.wb_enable = s;
            end
            MODE_BRANCH: dec.branch_taken = 1'b1;
            default:     dec.undef        = 1'b1;
        endcase
    end

`ifdef COND_EXEC_EN
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = !z;
            4'b0010: cond_eval = cf;
            4'b0011: cond_eval = !cf;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = !n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = !v;
            4'b1000: cond_eval = cf && !z;
            4'b1001: cond_eval = !cf || z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = !z && (n == v);
            4'b1101: cond_eval = z || (n != v);
            default: cond_eval = 1'b1;
        endcase
    endfunction

    assign cond_pass = cond_eval(cond, status);
`else
    logic unused_cond;
    assign unused_cond = ^{cond, status};
    assign cond_pass   = 1'b1;
`endif

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: all state here is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid  <= 1'b0;
            ctrl_q     <= '0;
            shadow_cnt <= '0;
        end else if (accept) begin
            if (shadow_cnt != '0) begin
                // Slot inside the branch shadow: drop it, including any branch it carries.
                out_valid  <= 1'b0;
                ctrl_q     <= '0;
                shadow_cnt <= shadow_cnt - 1'b1;
            end else begin
                out_valid                  <= 1'b1;
                ctrl_q.exe_cmd             <= dec.exe_cmd;
                ctrl_q.undef               <= dec.undef;
                ctrl_q.mem_read            <= dec.mem_read && cond_pass;
                ctrl_q.mem_write           <= dec.mem_write && cond_pass;
                ctrl_q.wb_enable           <= dec.wb_enable && cond_pass;
                ctrl_q.branch_taken        <= dec.branch_taken && cond_pass;
                ctrl_q.status_write_enable <= dec.status_write_enable && cond_pass;
                if (dec.branch_taken && cond_pass) shadow_cnt <= PENALTY;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign exe_cmd             = ctrl_q.exe_cmd;
    assign mem_read            = ctrl_q.mem_read;
    assign mem_write           = ctrl_q.mem_write;
    assign wb_enable           = ctrl_q.wb_enable;
    assign branch_taken        = ctrl_q.branch_taken;
    assign status_write_enable = ctrl_q.status_write_enable;
    assign undef               = ctrl_q.undef;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage (BRANCH_PENALTY = 2): vector table for single-cycle decode plus
// hand-written stall, condition, branch-shadow, flush and reset sequences.
module tb_ctrl_decode_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s;
    logic [3:0] cond;
    logic [3:0] status;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] exe_cmd;
    logic       mem_read, mem_write, wb_enable, branch_taken, status_write_enable, undef;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage #(
        .MODE_LEN      (2),
        .OPCODE_LEN    (4),
        .EXE_CMD_LEN   (4),
        .BRANCH_PENALTY(2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .mode               (mode),
        .opcode             (opcode),
        .s                  (s),
        .cond               (cond),
        .status             (status),
        .flush              (flush),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .exe_cmd            (exe_cmd),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .wb_enable          (wb_enable),
        .branch_taken       (branch_taken),
        .status_write_enable(status_write_enable),
        .undef              (undef)
    );

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [3:0] opcode;
        logic       s;
        logic [3:0] cond;
        logic [3:0] exe;
        logic       mr, mw, wb, bt, swe, ud;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bundle(input string name, input logic ov, input logic [3:0] exe,
                                input logic mr, input logic mw, input logic wb,
                                input logic bt, input logic swe, input logic ud);
        check({name, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({name, ".exe_cmd"}, 32'(exe_cmd), 32'(exe));
        check({name, ".mem_read"}, 32'(mem_read), 32'(mr));
        check({name, ".mem_write"}, 32'(mem_write), 32'(mw));
        check({name, ".wb_enable"}, 32'(wb_enable), 32'(wb));
        check({name, ".branch_taken"}, 32'(branch_taken), 32'(bt));
        check({name, ".status_we"}, 32'(status_write_enable), 32'(swe));
        check({name, ".undef"}, 32'(undef), 32'(ud));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [3:0] op, input logic sb,
                         input logic [3:0] c, input logic [3:0] st);
        in_valid = 1'b1;
        mode     = m;
        opcode   = op;
        s        = sb;
        cond     = c;
        status   = st;
    endtask

    function automatic vec_t mk(input string n, input logic [1:0] m, input logic [3:0] op,
                                input logic sb, input logic [3:0] c, input logic [3:0] exe,
                                input logic mr, input logic mw, input logic wb,
                                input logic bt, input logic swe, input logic ud);
        vec_t v;
        v.name = n; v.mode = m; v.opcode = op; v.s = sb; v.cond = c; v.exe = exe;
        v.mr = mr; v.mw = mw; v.wb = wb; v.bt = bt; v.swe = swe; v.ud = ud;
        return v;
    endfunction

    initial begin
        //                 name      mode   opcode  s     cond     exe      mr mw wb bt swe ud
        vecs.push_back(mk("adds",   2'b00, 4'b0100, 1'b1, 4'b1110, 4'b0010, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("add",    2'b00, 4'b0100, 1'b0, 4'b1110, 4'b0010, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("mov",    2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0001, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("mvn",    2'b00, 4'b1111, 1'b0, 4'b1110, 4'b1001, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("adc",    2'b00, 4'b0101, 1'b0, 4'b1110, 4'b0011, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("sub",    2'b00, 4'b0010, 1'b0, 4'b1110, 4'b0100, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("sbcs",   2'b00, 4'b0110, 1'b1, 4'b1110, 4'b0101, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("and",    2'b00, 4'b0000, 1'b0, 4'b1110, 4'b0110, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("orr",    2'b00, 4'b1100, 1'b0, 4'b1110, 4'b0111, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("eor",    2'b00, 4'b0001, 1'b0, 4'b1110, 4'b1000, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("cmp",    2'b00, 4'b1010, 1'b0, 4'b1110, 4'b0100, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("tst",    2'b00, 4'b1000, 1'b0, 4'b1110, 4'b0110, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("op0011", 2'b00, 4'b0011, 1'b1, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("op1110", 2'b00, 4'b1110, 1'b0, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("mode11", 2'b11, 4'b0100, 1'b1, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ldr",    2'b01, 4'b0000, 1'b1, 4'b1110, 4'b0010, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("str",    2'b01, 4'b0000, 1'b0, 4'b1110, 4'b0010, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("add_nv", 2'b00, 4'b0100, 1'b1, 4'b1111, 4'b0010, 0, 0, 1, 0, 1, 0));

        rst = 1'b1; in_valid = 1'b0; mode = '0; opcode = '0; s = 1'b0;
        cond = 4'b1110; status = '0; flush = 1'b0; out_ready = 1'b1;
        step();
        step();
        check_bundle("reset", 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Back-to-back single-cycle decode, downstream always ready.
        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].opcode, vecs[i].s, vecs[i].cond, 4'b0000);
            step();
            check_bundle(vecs[i].name, 1, vecs[i].exe, vecs[i].mr, vecs[i].mw, vecs[i].wb,
                         vecs[i].bt, vecs[i].swe, vecs[i].ud);
        end
        in_valid = 1'b0;
        step();
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // LDR held for three cycles while downstream stalls.
        out_ready = 1'b0;
        drive(2'b01, 4'b0000, 1'b1, 4'b1110, 4'b0000);
        step();
        check_bundle("ldr_stall", 1, 4'b0010, 1, 0, 1, 0, 0, 0);
        drive(2'b00, 4'b0100, 1'b0, 4'b1110, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.in_ready", 32'(in_ready), 32'd0);
            step();
            check_bundle("ldr_hold", 1, 4'b0010, 1, 0, 1, 0, 0, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(in_ready), 32'd1);
        step();
        check("consumed.out_valid", 32'(out_valid), 32'd0);

        // Conditional execution.
        drive(2'b00, 4'b0010, 1'b1, 4'b0000, 4'b0100);
        step();
        check_bundle("subseq_z1", 1, 4'b0100, 0, 0, 1, 0, 1, 0);
        drive(2'b00, 4'b0010, 1'b1, 4'b0000, 4'b0000);
        step();
        check("subseq_z0.out_valid", 32'(out_valid), 32'd1);
        check("subseq_z0.undef", 32'(undef), 32'd0);
`ifdef COND_EXEC_EN
        check("subseq_z0.wb_enable", 32'(wb_enable), 32'd0);
        check("subseq_z0.status_we", 32'(status_write_enable), 32'd0);
        drive(2'b00, 4'b0100, 1'b0, 4'b1011, 4'b1000);
        step();
        check("addlt_pass.wb_enable", 32'(wb_enable), 32'd1);
        drive(2'b00, 4'b0100, 1'b0, 4'b1011, 4'b1001);
        step();
        check("addlt_fail.wb_enable", 32'(wb_enable), 32'd0);
        drive(2'b01, 4'b0000, 1'b1, 4'b1000, 4'b0110);
        step();
        check("ldrhi_fail.mem_read", 32'(mem_read), 32'd0);
        drive(2'b10, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        step();
        check("beq_fail.out_valid", 32'(out_valid), 32'd1);
        check("beq_fail.branch_taken", 32'(branch_taken), 32'd0);
        drive(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000);
        step();
        check_bundle("mov_after_beq", 1, 4'b0001, 0, 0, 1, 0, 0, 0);
`else
        check("subseq_z0.wb_enable", 32'(wb_enable), 32'd1);
        check("subseq_z0.status_we", 32'(status_write_enable), 32'd1);
`endif
        in_valid = 1'b0;
        step();

        // Taken branch squashes the next two accepted slots.
        drive(2'b10, 4'b0000, 1'b0, 4'b1110, 4'b0000);
        step();
        check_bundle("b", 1, 4'b0000, 0, 0, 0, 1, 0, 0);
        drive(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000);
        step();
        check("mov_squash.out_valid", 32'(out_valid), 32'd0);
        drive(2'b00, 4'b0100, 1'b0, 4'b1110, 4'b0000);
        step();
        check("add_squash.out_valid", 32'(out_valid), 32'd0);
        drive(2'b00, 4'b0001, 1'b0, 4'b1110, 4'b0000);
        step();
        check_bundle("eor_after", 1, 4'b1000, 0, 0, 1, 0, 0, 0);

        // A branch inside the shadow is dropped and does not reload the counter.
        drive(2'b10, 4'b0000, 1'b0, 4'b1110, 4'b0000);
        step();
        check("b1.branch_taken", 32'(branch_taken), 32'd1);
        step();
        check("b2_squash.out_valid", 32'(out_valid), 32'd0);
        check("b2_squash.branch_taken", 32'(branch_taken), 32'd0);
        drive(2'b00, 4'b0100, 1'b0, 4'b1110, 4'b0000);
        step();
        check("add_squash2.out_valid", 32'(out_valid), 32'd0);
        drive(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000);
        step();
        check_bundle("mov_no_reload", 1, 4'b0001, 0, 0, 1, 0, 0, 0);
        in_valid = 1'b0;
        step();

        // Flush with a pending branch bundle and an active shadow.
        out_ready = 1'b0;
        drive(2'b10, 4'b0000, 1'b0, 4'b1110, 4'b0000);
        step();
        check("b_pending.branch_taken", 32'(branch_taken), 32'd1);
        flush = 1'b1;
        drive(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000);
        #1;
        check("flush.in_ready", 32'(in_ready), 32'd0);
        step();
        check_bundle("flushed", 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        check_bundle("mov_post_flush", 1, 4'b0001, 0, 0, 1, 0, 0, 0);
        in_valid = 1'b0;
        step();

        // Reset while a branch bundle is stalled and the shadow is loaded.
        drive(2'b10, 4'b0000, 1'b0, 4'b1110, 4'b0000);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check("b_stalled.branch_taken", 32'(branch_taken), 32'd1);
        rst = 1'b1;
        step();
        check_bundle("reset_mid_stall", 0, 4'b0000, 0, 0, 0, 0, 0, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(2'b00, 4'b1101, 1'b0, 4'b1110, 4'b0000);
        step();
        check_bundle("mov_post_reset", 1, 4'b0001, 0, 0, 1, 0, 0, 0);
        in_valid = 1'b0;
        step();
        check("final.out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
